// File: rtl/window_feeder.sv
// window_feeder: serialises a column-major pixel stream into the data_matrix sliding-window register.
// Define WINDOW_FEEDER_ZERO_PAD_EN to add (KERNEL_WIDTH-1)/2 zero columns before and after each row.
module window_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int ROW_WIDTH    = 5,
    parameter int COL_HEIGHT   = 3,
    parameter int KERNEL_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  processing,
    output logic                  shifting_enable,
    output logic [DATA_WIDTH-1:0] shifting_data,
    output logic                  parallel_load_en,
    output logic                  window_valid,
    output logic                  done
);

`ifdef WINDOW_FEEDER_ZERO_PAD_EN
    localparam int PAD = (KERNEL_WIDTH - 1) / 2;
`else
    localparam int PAD = 0;
`endif
    localparam int TOTAL_COLS = ROW_WIDTH + 2 * PAD;
    localparam int ROW_W      = $clog2(COL_HEIGHT + 1);
    localparam int COL_W      = $clog2(TOTAL_COLS + 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(COL_HEIGHT - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(TOTAL_COLS - 1);
    localparam logic [COL_W-1:0] KW       = COL_W'(KERNEL_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
`ifdef WINDOW_FEEDER_ZERO_PAD_EN
        S_PAD,
`endif
        S_LOAD,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ROW_W-1:0]        row_cnt, row_d;
    logic [COL_W-1:0]        col_cnt, col_d, col_inc;
    logic                    proc_d, se_d, ple_d, wv_d, done_d, advance;
    logic [DATA_WIDTH-1:0]   sd_d;
    state_t                  first_state, next_col_state;

`ifdef WINDOW_FEEDER_ZERO_PAD_EN
    function automatic logic is_pad_col(input logic [COL_W-1:0] c);
        return (c < COL_W'(PAD)) || (c >= COL_W'(PAD + ROW_WIDTH));
    endfunction

    assign first_state    = is_pad_col('0) ? S_PAD : S_SHIFT;
    assign next_col_state = is_pad_col(col_inc) ? S_PAD : S_SHIFT;
`else
    assign first_state    = S_SHIFT;
    assign next_col_state = S_SHIFT;
`endif

    assign col_inc  = col_cnt + COL_W'(1);
    assign in_ready = (state_q == S_SHIFT);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q          <= S_IDLE;
            row_cnt          <= '0;
            col_cnt          <= '0;
            processing       <= 1'b0;
            shifting_enable  <= 1'b0;
            shifting_data    <= '0;
            parallel_load_en <= 1'b0;
            window_valid     <= 1'b0;
            done             <= 1'b0;
        end else begin
            state_q          <= state_d;
            row_cnt          <= row_d;
            col_cnt          <= col_d;
            processing       <= proc_d;
            shifting_enable  <= se_d;
            shifting_data    <= sd_d;
            parallel_load_en <= ple_d;
            window_valid     <= wv_d;
            done             <= done_d;
        end
    end

    // A column is shifted one pixel per cycle, then committed by a single load cycle.
    always_comb begin
        state_d = state_q;
        row_d   = row_cnt;
        col_d   = col_cnt;
        proc_d  = processing;
        se_d    = 1'b0;
        sd_d    = '0;
        ple_d   = 1'b0;
        wv_d    = 1'b0;
        done_d  = 1'b0;
        advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                row_d  = '0;
                col_d  = '0;
                proc_d = start;
                if (start) begin
                    state_d = first_state;
                end
            end
            S_SHIFT: begin
                if (in_valid) begin
                    se_d    = 1'b1;
                    sd_d    = in_data;
                    advance = 1'b1;
                end
            end
`ifdef WINDOW_FEEDER_ZERO_PAD_EN
            S_PAD: begin
                se_d    = 1'b1;
                advance = 1'b1;
            end
`endif
            S_LOAD: begin
                ple_d = 1'b1;
                col_d = col_inc;
                wv_d  = (col_inc >= KW);
                if (col_cnt == LAST_COL) begin
                    state_d = S_DONE;
                end else begin
                    state_d = next_col_state;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                row_d   = '0;
                col_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            if (row_cnt == LAST_ROW) begin
                row_d   = '0;
                state_d = S_LOAD;
            end else begin
                row_d = row_cnt + ROW_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_window_feeder.sv
// tb_window_feeder: table-driven and randomized row passes checked against an event-timeline model
// of the pixel stream, column loads, windows and pass framing.
module tb_window_feeder;
    localparam int DW = 8;
    localparam int RW = 5;
    localparam int CH = 3;
    localparam int KW = 3;
`ifdef WINDOW_FEEDER_ZERO_PAD_EN
    localparam int P = (KW - 1) / 2;
`else
    localparam int P = 0;
`endif
    localparam int TC       = RW + 2 * P;
    localparam int MIN_PASS = TC * (CH + 1) + 2;
    localparam int WINDOWS  = TC - KW + 1;
    localparam int BUDGET   = 400;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          processing;
    logic          shifting_enable;
    logic [DW-1:0] shifting_data;
    logic          parallel_load_en;
    logic          window_valid;
    logic          done;

    int checks = 0;
    int errors = 0;

    int pass_loads, pass_windows, pass_dones, pass_done_cyc, pass_stalls, pass_pixels;

    typedef struct {
        int stall_at;
        int stall_len;
        bit extra_start;
        int exp_done;
    } vec_t;

    vec_t vecs[4];

    window_feeder #(
        .DATA_WIDTH(DW),
        .ROW_WIDTH(RW),
        .COL_HEIGHT(CH),
        .KERNEL_WIDTH(KW)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .processing(processing),
        .shifting_enable(shifting_enable),
        .shifting_data(shifting_data),
        .parallel_load_en(parallel_load_en),
        .window_valid(window_valid),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        checkOutput({tag, "_processing"}, 64'(processing), 64'(0));
        checkOutput({tag, "_shifting_enable"}, 64'(shifting_enable), 64'(0));
        checkOutput({tag, "_shifting_data"}, 64'(shifting_data), 64'(0));
        checkOutput({tag, "_parallel_load_en"}, 64'(parallel_load_en), 64'(0));
        checkOutput({tag, "_window_valid"}, 64'(window_valid), 64'(0));
        checkOutput({tag, "_done"}, 64'(done), 64'(0));
    endtask

    // Safety properties that must hold on every cycle outside reset.
    always @(negedge clk) begin
        if (arst_n) begin
            checkOutput("se_ple_exclusive", 64'(shifting_enable && parallel_load_en), 64'(0));
            checkOutput("activity_without_processing",
                        64'((shifting_enable || parallel_load_en) && !processing), 64'(0));
            checkOutput("shifting_data_known", 64'($isunknown(shifting_data)), 64'(0));
            checkOutput("shifting_data_zero_when_idle",
                        64'(!shifting_enable && (shifting_data != '0)), 64'(0));
            checkOutput("window_without_load", 64'(window_valid && !parallel_load_en), 64'(0));
        end
    end

    // One row pass. Column k completes when its CH-th shift is seen; its load follows one cycle
    // later, and done one cycle after the last load. reset_col >= 0 aborts the pass with a reset
    // while that many columns have been shifted and the load is pending.
    task automatic applyStimulus(input int stall_at, input int stall_len, input bit rnd,
                                 input bit extra_start, input int reset_col);
        int cyc = 0;
        int acc = 0;
        int cols = 0;
        int in_col = 0;
        int last_end = -10;
        int stall_cnt = 0;
        bit collecting, img_col, ready_exp, will_shift, exp_ple, exp_wv, exp_done;
        logic [DW-1:0] pix, shift_val;

        pass_loads = 0;
        pass_windows = 0;
        pass_dones = 0;
        pass_done_cyc = -1;
        pass_stalls = 0;
        pass_pixels = 0;
        pix = rnd ? DW'($urandom) : DW'(1);

        start = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        checkOutput("processing_rise", 64'(processing), 64'(1));

        while (cyc < BUDGET && pass_dones == 0) begin
            collecting = (cols < TC) && (cyc != last_end);
            img_col = (cols >= P) && (cols < P + RW);
            ready_exp = collecting && img_col;
            checkOutput("in_ready", 64'(in_ready), 64'(ready_exp));

            if (reset_col >= 0 && cols == reset_col && cyc == last_end) begin
                arst_n = 1'b0;
                #1;
                checkAllZero("reset_mid_pass");
                #2;
                arst_n = 1'b1;
                return;
            end

            if (rnd) begin
                in_valid = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid = !(acc == stall_at && stall_cnt < stall_len);
            end
            in_data = pix;
            start = extra_start && (cyc == 3);
            will_shift = collecting && (img_col ? in_valid : 1'b1);
            shift_val = img_col ? pix : '0;
            if (ready_exp && !in_valid) begin
                pass_stalls++;
                if (acc == stall_at) stall_cnt++;
            end

            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;

            exp_ple = (last_end > 0) && (cyc == last_end + 1);
            exp_wv = exp_ple && (cols >= KW);
            exp_done = (cols == TC) && (cyc == last_end + 2);
            checkOutput("shifting_enable", 64'(shifting_enable), 64'(will_shift));
            checkOutput("shifting_data", 64'(shifting_data), will_shift ? 64'(shift_val) : 64'(0));
            checkOutput("parallel_load_en", 64'(parallel_load_en), 64'(exp_ple));
            checkOutput("window_valid", 64'(window_valid), 64'(exp_wv));
            checkOutput("done", 64'(done), 64'(exp_done));
            checkOutput("processing", 64'(processing), 64'(1));

            if (parallel_load_en) pass_loads++;
            if (window_valid) pass_windows++;
            if (done) begin
                pass_dones++;
                pass_done_cyc = cyc;
            end
            if (will_shift) begin
                if (img_col) begin
                    acc++;
                    pix = rnd ? DW'($urandom) : DW'(acc + 1);
                end
                in_col++;
                if (in_col == CH) begin
                    in_col = 0;
                    cols++;
                    last_end = cyc;
                end
            end
        end

        in_valid = 1'b0;
        pass_pixels = acc;
        @(posedge clk);
        #1;
        checkOutput("processing_after_done", 64'(processing), 64'(0));
        checkOutput("done_single_cycle", 64'(done), 64'(0));
    endtask

    task automatic checkPass(input int exp_done);
        checkOutput("pass_done_count", 64'(pass_dones), 64'(1));
        checkOutput("pass_done_cycle", 64'(pass_done_cyc), 64'(exp_done));
        checkOutput("pass_loads", 64'(pass_loads), 64'(TC));
        checkOutput("pass_windows", 64'(pass_windows), 64'(WINDOWS));
        checkOutput("pass_pixels", 64'(pass_pixels), 64'(RW * CH));
    endtask

    initial begin
        vecs[0] = '{stall_at: -1, stall_len: 0, extra_start: 1'b0, exp_done: MIN_PASS};
        vecs[1] = '{stall_at: 4,  stall_len: 2, extra_start: 1'b0, exp_done: MIN_PASS + 2};
        vecs[2] = '{stall_at: 0,  stall_len: 3, extra_start: 1'b1, exp_done: MIN_PASS + 3};
        vecs[3] = '{stall_at: 14, stall_len: 1, extra_start: 1'b0, exp_done: MIN_PASS + 1};

        arst_n = 1'b0;
        #12;
        checkAllZero("reset");
        arst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].stall_at, vecs[i].stall_len, 1'b0, vecs[i].extra_start, -1);
            checkPass(vecs[i].exp_done);
        end

        applyStimulus(-1, 0, 1'b0, 1'b0, 2);
        applyStimulus(-1, 0, 1'b0, 1'b0, -1);
        checkPass(MIN_PASS);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(-1, 0, 1'b1, 1'b0, -1);
            checkPass(MIN_PASS + pass_stalls);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
